// File: rtl/dmem_access_unit.sv
// Purpose: memory-stage data RAM access with byte/half lanes, load extension and misalignment detection.
// Latency: LAT cycles of stall per access, result in cycle LAT; misaligned accesses fault in cycle 1.
// Backpressure: stall holds the pipeline from the request cycle until the result cycle.
module dmem_access_unit #(
    parameter int ADDR_SIZE   = 32,
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LAT         = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 memwrite,
    input  logic                 lb,
    input  logic                 lh,
    input  logic                 sb,
    input  logic                 sh,
    input  logic                 lunsigned,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [XLEN-1:0]      writedata,
    input  logic [ADDR_SIZE-1:0] pcM,
    output logic                 stall,
    output logic [XLEN-1:0]      rdata,
    output logic                 rdata_valid,
    output logic                 misalign,
    output logic [ADDR_SIZE-1:0] misalign_pc
);

    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [2:0]      cnt;

    // request captured at acceptance, used while BUSY
    logic            r_mw;
    logic            r_byte;
    logic            r_half;
    logic            r_lu;
    logic [IW+1:0]   r_addr;
    logic [XLEN-1:0] r_wdata;

    // decoded live request; the load flags win when memwrite is low
    logic            in_byte;
    logic            in_half;
    logic            in_mis;

    // request currently being serviced: live inputs in IDLE, captured copy otherwise
    logic            cur_mw;
    logic            cur_byte;
    logic            cur_half;
    logic            cur_lu;
    logic [IW+1:0]   cur_addr;
    logic [XLEN-1:0] cur_wdata;
    logic [IW-1:0]   cur_idx;
    logic [1:0]      cur_lane;

    logic            access;
    logic            wr_en;
    logic [3:0]      lane_en;
    logic [XLEN-1:0] wdata_al;
    logic [XLEN-1:0] rd_word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // upper address bits are deliberately ignored so addresses wrap modulo RAM size
    logic            unused_addr;
    assign unused_addr = &{1'b0, addr[ADDR_SIZE-1:IW+2]};

    assign in_byte = memwrite ? sb : lb;
    assign in_half = !in_byte && (memwrite ? sh : lh);
    assign in_mis  = in_half ? addr[0] : (!in_byte && (addr[1:0] != 2'b00));

    assign cur_mw    = (state == IDLE) ? memwrite        : r_mw;
    assign cur_byte  = (state == IDLE) ? in_byte         : r_byte;
    assign cur_half  = (state == IDLE) ? in_half         : r_half;
    assign cur_lu    = (state == IDLE) ? lunsigned       : r_lu;
    assign cur_addr  = (state == IDLE) ? addr[IW+1:0]    : r_addr;
    assign cur_wdata = (state == IDLE) ? writedata       : r_wdata;
    assign cur_idx   = cur_addr[IW+1:2];
    assign cur_lane  = cur_addr[1:0];

    // the RAM is touched exactly once per aligned access, on the edge into DONE;
    // reset low suppresses it so an in-flight store is dropped
    assign access = reset && (((state == IDLE) && req_valid && (LAT == 1) && !in_mis) ||
                              ((state == BUSY) && (cnt <= 3'd1)));
    assign wr_en  = access && cur_mw;

    // stall covers the request cycle and every BUSY cycle; reset clears it at once
    assign stall = reset && (((state == IDLE) && req_valid) || (state == BUSY));

    // byte-lane write enables and store data replicated onto the addressed lanes
    always_comb begin
        lane_en  = 4'b1111;
        wdata_al = cur_wdata;
        if (cur_byte) begin
            lane_en  = 4'b0001 << cur_lane;
            wdata_al = {4{cur_wdata[7:0]}};
        end else if (cur_half) begin
            lane_en  = cur_lane[1] ? 4'b1100 : 4'b0011;
            wdata_al = {2{cur_wdata[15:0]}};
        end
    end

    // lane selection and sign/zero extension of the addressed word
    always_comb begin
        rd_word = mem[cur_idx];
        ld_byte = rd_word[{cur_lane, 3'b000} +: 8];
        ld_half = cur_lane[1] ? rd_word[31:16] : rd_word[15:0];
        ld_ext  = rd_word;
        if (cur_byte) begin
            ld_ext = cur_lu ? {{(XLEN-8){1'b0}}, ld_byte} : {{(XLEN-8){ld_byte[7]}}, ld_byte};
        end else if (cur_half) begin
            ld_ext = cur_lu ? {{(XLEN-16){1'b0}}, ld_half} : {{(XLEN-16){ld_half[15]}}, ld_half};
        end
    end

    // data RAM: byte-lane writes, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[cur_idx][i*8 +: 8] <= wdata_al[i*8 +: 8];
                end
            end
        end
    end

    // access sequencer with registered result and fault outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            r_mw        <= 1'b0;
            r_byte      <= 1'b0;
            r_half      <= 1'b0;
            r_lu        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            misalign_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rdata_valid <= 1'b0;
                    misalign    <= 1'b0;
                    if (req_valid) begin
                        r_mw    <= memwrite;
                        r_byte  <= in_byte;
                        r_half  <= in_half;
                        r_lu    <= lunsigned;
                        r_addr  <= addr[IW+1:0];
                        r_wdata <= writedata;
                        if (in_mis) begin
                            state       <= DONE;
                            misalign    <= 1'b1;
                            misalign_pc <= pcM;
                        end else if (LAT == 1) begin
                            state <= DONE;
                            if (!memwrite) begin
                                rdata       <= ld_ext;
                                rdata_valid <= 1'b1;
                            end
                        end else begin
                            state <= BUSY;
                            cnt   <= 3'(LAT - 1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt <= 3'd1) begin
                        state <= DONE;
                        cnt   <= 3'd0;
                        if (!r_mw) begin
                            rdata       <= ld_ext;
                            rdata_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    rdata_valid <= 1'b0;
                    misalign    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Purpose: self-checking bench for dmem_access_unit with a reference RAM model and result scoreboard.
// Latency: each access expected to finish in cycle LAT (misaligned: cycle 1).
// Backpressure: stall length is measured per access and compared against the expected latency.
module tb_dmem_access_unit;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        memwrite;
    logic        lb;
    logic        lh;
    logic        sb;
    logic        sh;
    logic        lunsigned;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] pcM;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign;
    logic [31:0] misalign_pc;

    typedef struct {
        logic        ld;
        logic        mis;
        logic [31:0] data;
        logic [31:0] pc;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl [1024];
    logic [31:0] last_rd;
    int          checks = 0;
    int          errors = 0;

    dmem_access_unit #(
        .ADDR_SIZE(32), .XLEN(32), .DEPTH_WORDS(1024), .LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .memwrite(memwrite),
        .lb(lb), .lh(lh), .sb(sb), .sh(sh), .lunsigned(lunsigned),
        .addr(addr), .writedata(writedata), .pcM(pcM),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .misalign(misalign), .misalign_pc(misalign_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One access: model it, queue the expectation, drive it, then check the result cycle
    // and the following idle cycle. Entered and left #1 after an edge with the DUT in IDLE.
    task automatic acc(input string tag, input logic mw, input logic [1:0] sz, input logic lu,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
        exp_t        e;
        exp_t        got;
        int          cyc;
        int          idx;
        int          lane;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        idx    = int'(a[11:2]);
        lane   = int'(a[1:0]);
        e.mis  = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        e.ld   = !mw && !e.mis;
        e.pc   = pc;
        e.lat  = e.mis ? 1 : LAT;
        e.data = 32'h0;
        if (!e.mis) begin
            if (mw) begin
                if (sz == 2'd0)      mdl[idx][lane*8 +: 8] = wd[7:0];
                else if (sz == 2'd1) mdl[idx][(lane/2)*16 +: 16] = wd[15:0];
                else                 mdl[idx] = wd;
            end else begin
                w = mdl[idx];
                b = 8'(w >> (lane * 8));
                h = a[1] ? w[31:16] : w[15:0];
                if (sz == 2'd0)      e.data = lu ? {24'h0, b} : {{24{b[7]}}, b};
                else if (sz == 2'd1) e.data = lu ? {16'h0, h} : {{16{h[15]}}, h};
                else                 e.data = w;
                last_rd = e.data;
            end
        end
        sbq.push_back(e);

        req_valid = 1'b1;
        memwrite  = mw;
        lb        = !mw && sz == 2'd0;
        lh        = !mw && sz == 2'd1;
        sb        = mw && sz == 2'd0;
        sh        = mw && sz == 2'd1;
        lunsigned = lu;
        addr      = a;
        writedata = wd;
        pcM       = pc;
        #1;
        chk({tag, ":stall_req"}, {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (stall && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        got = sbq.pop_front();
        chk({tag, ":lat"}, cyc, got.lat);
        chk({tag, ":rvalid"}, {31'h0, rdata_valid}, {31'h0, got.ld});
        chk({tag, ":misalign"}, {31'h0, misalign}, {31'h0, got.mis});
        if (got.ld)  chk({tag, ":rdata"}, rdata, got.data);
        if (got.mis) chk({tag, ":mis_pc"}, misalign_pc, got.pc);
        @(posedge clk); #1;
        chk({tag, ":rvalid_off"}, {31'h0, rdata_valid}, 32'h0);
        chk({tag, ":mis_off"}, {31'h0, misalign}, 32'h0);
        chk({tag, ":rdata_hold"}, rdata, last_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;
        last_rd   = 32'h0;
        reset     = 1'b0;
        req_valid = 1'b0;
        memwrite  = 1'b0;
        lb        = 1'b0;
        lh        = 1'b0;
        sb        = 1'b0;
        sh        = 1'b0;
        lunsigned = 1'b0;
        addr      = 32'h0;
        writedata = 32'h0;
        pcM       = 32'h0;
        #12;
        chk("rst:stall", {31'h0, stall}, 32'h0);
        chk("rst:rdata", rdata, 32'h0);
        chk("rst:rvalid", {31'h0, rdata_valid}, 32'h0);
        chk("rst:misalign", {31'h0, misalign}, 32'h0);
        chk("rst:mis_pc", misalign_pc, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle:stall", {31'h0, stall}, 32'h0);

        acc("sw10",   1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h100);
        acc("lw10",   1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h104);
        acc("sw20",   1'b1, 2'd2, 1'b0, 32'h20,   32'h11223344, 32'h108);
        acc("sb23",   1'b1, 2'd0, 1'b0, 32'h23,   32'hFFFFFF80, 32'h10C);
        acc("lb23",   1'b0, 2'd0, 1'b0, 32'h23,   32'h0,        32'h110);
        acc("lbu23",  1'b0, 2'd0, 1'b1, 32'h23,   32'h0,        32'h114);
        acc("lw20",   1'b0, 2'd2, 1'b0, 32'h20,   32'h0,        32'h118);
        acc("lbu21",  1'b0, 2'd0, 1'b1, 32'h21,   32'h0,        32'h11C);
        acc("sw40",   1'b1, 2'd2, 1'b0, 32'h40,   32'hA5A5A5A5, 32'h120);
        acc("sh42",   1'b1, 2'd1, 1'b0, 32'h42,   32'h12348001, 32'h124);
        acc("lh42",   1'b0, 2'd1, 1'b0, 32'h42,   32'h0,        32'h128);
        acc("lhu42",  1'b0, 2'd1, 1'b1, 32'h42,   32'h0,        32'h12C);
        acc("lh40",   1'b0, 2'd1, 1'b0, 32'h40,   32'h0,        32'h130);
        acc("lw40",   1'b0, 2'd2, 1'b0, 32'h40,   32'h0,        32'h134);
        acc("lh41",   1'b0, 2'd1, 1'b0, 32'h41,   32'h0,        32'h1C);
        acc("sw42m",  1'b1, 2'd2, 1'b0, 32'h42,   32'hFFFFFFFF, 32'h20);
        acc("lw40b",  1'b0, 2'd2, 1'b0, 32'h40,   32'h0,        32'h138);
        acc("sw1004", 1'b1, 2'd2, 1'b0, 32'h1004, 32'h0BADF00D, 32'h13C);
        acc("lw0004", 1'b0, 2'd2, 1'b0, 32'h4,    32'h0,        32'h140);

        // store aborted by reset while BUSY; RAM must keep the old word
        req_valid = 1'b1;
        memwrite  = 1'b1;
        lb        = 1'b0;
        lh        = 1'b0;
        sb        = 1'b0;
        sh        = 1'b0;
        addr      = 32'h10;
        writedata = 32'hCAFEF00D;
        pcM       = 32'h144;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort:busy_stall", {31'h0, stall}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        last_rd = 32'h0;
        chk("abort:stall", {31'h0, stall}, 32'h0);
        chk("abort:rdata", rdata, 32'h0);
        chk("abort:rvalid", {31'h0, rdata_valid}, 32'h0);
        chk("abort:misalign", {31'h0, misalign}, 32'h0);
        chk("abort:mis_pc", misalign_pc, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        chk("abort:stall_hold", {31'h0, stall}, 32'h0);
        reset = 1'b1;
        acc("lw10rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h148);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage data access unit for the pipelined xgriscv core. It sits directly downstream of the core's memory-stage outputs (address, store data, write enable, byte/half flags, pcM) and returns load data to the writeback path. It contains the word-organised data RAM with byte-lane handling and models a fixed multi-cycle access latency. While an access is in flight it stalls the pipeline. It also flags misaligned accesses instead of performing them.

## Interface
- ADDR_SIZE, 32, address width
- XLEN, 32, data width
- DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two)
- LAT, 2, access latency in cycles, legal range 1..7
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- req_valid  in  1  memory-stage instruction performs a load or store
- memwrite  in  1  1 = store, 0 = load
- lb, lh  in  1  load byte / load half; neither set = load word
- sb, sh  in  1  store byte / store half; neither set = store word
- lunsigned  in  1  zero-extend byte/half loads
- addr  in  ADDR_SIZE  byte address
- writedata  in  XLEN  store data, right-aligned
- pcM  in  ADDR_SIZE  PC of the memory-stage instruction
- stall  out  1  hold pipeline (F/D/E/M) this cycle
- rdata  out  XLEN  extended load data
- rdata_valid  out  1  rdata valid this cycle (loads only)
- misalign  out  1  one-cycle fault pulse
- misalign_pc  out  ADDR_SIZE  pcM of the faulting access, held until the next fault

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - req_valid=1: capture all request inputs at the clock edge.
  - stall=1 combinationally in this cycle.
  - Go to BUSY with counter = LAT-1.
  - If LAT=1 or the request is misaligned, go straight to DONE.
- BUSY:
  - stall=1.
  - Counter decrements each cycle; at 0, go to DONE.
  - Store commit happens on the edge BUSY→DONE, or IDLE→DONE when LAT=1.
- DONE:
  - stall=0.
  - Load: rdata_valid=1, rdata = extended data.
  - Misaligned: misalign=1, rdata_valid=0, no RAM access.
  - Always go to IDLE next cycle; req_valid is ignored in DONE because the inputs still belong to the retiring instruction.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo RAM size.
- Misaligned means: half access with addr[0]=1, or word access with addr[1:0]≠0. Byte accesses are never misaligned.
- Stores:
  - sb writes lane addr[1:0] with writedata[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with writedata[15:0].
  - A word store writes all four lanes. Other lanes are untouched.
- Loads:
  - Select lane(s) by addr[1:0].
  - Sign-extend bit 7/15 unless lunsigned; word loads pass through.
  - lb/lh have priority over a simultaneous sb/sh flag, selected by memwrite.
- RAM contents are not cleared by reset.

## Timing
- Reset values: state IDLE, counter 0, stall 0, rdata 0, rdata_valid 0, misalign 0, misalign_pc 0.
- Stall length per access is exactly LAT cycles; rdata_valid appears in cycle LAT, counting the request cycle as cycle 0.
- Misaligned access: stall for 1 cycle, then misalign in cycle 1.
- rdata, rdata_valid and misalign are registered; rdata holds its value outside DONE, rdata_valid does not.
- Back-to-back requests: the next request is accepted in the cycle after DONE. Throughput is one access per LAT+1 cycles.
- Reset asserted mid-access: state returns to IDLE immediately.
  - A store not yet committed is dropped.
  - stall deasserts asynchronously.
- req_valid=0 in IDLE: no state change, stall=0.

## Test plan
- LAT=2: store word 0xDEADBEEF to 0x10, then load word from 0x10 → stall high for 2 cycles per access, rdata=0xDEADBEEF with rdata_valid in cycle 2.
- sb 0x80 to 0x23, then lb 0x23 → 0xFFFFFF80; lbu 0x23 → 0x00000080; lw 0x20 → only byte 3 changed from its prior value.
- sh 0x8001 to 0x42, then lh → 0xFFFF8001, lhu → 0x00008001.
- lh at 0x41 with pcM=0x1C → stall for 1 cycle, misalign=1, misalign_pc=0x1C, RAM unchanged.
- DEPTH_WORDS=1024: store to 0x1004, then load 0x0004 → same data, showing address wrap.
- Store with reset pulsed low during BUSY → all outputs 0 immediately, a subsequent load returns the old word, FSM accepts a new request on the first edge after reset is released.
